// File: rtl/sram_1rw1r_param.sv
// sram_1rw1r_param: parametrised 1RW + 1R synchronous SRAM.
// Port 0 reads or writes with per-lane write masking; port 1 only reads.
// After reset the array can be swept to zero before any request is accepted.
// Reads are captured at the request edge and presented one or two clocks later.
module sram_1rw1r_param #(
   parameter int DATA_WIDTH     = 32,
   parameter int ADDR_WIDTH     = 8,
   parameter int WMASK_WIDTH    = 8,
   parameter int READ_LATENCY   = 1,
   parameter int COLLISION_MODE = 1,
   parameter int CLEAR_ON_RESET = 1
) (
   input  logic                              clk,
   input  logic                              rstb,
   input  logic                              csb0,
   input  logic                              web0,
   input  logic [DATA_WIDTH/WMASK_WIDTH-1:0] wmask0,
   input  logic [ADDR_WIDTH-1:0]             addr0,
   input  logic [DATA_WIDTH-1:0]             din0,
   output logic [DATA_WIDTH-1:0]             dout0,
   output logic                              dout0_vld,
   input  logic                              csb1,
   input  logic [ADDR_WIDTH-1:0]             addr1,
   output logic [DATA_WIDTH-1:0]             dout1,
   output logic                              dout1_vld,
   output logic                              init_done
);

   localparam int NUM_WMASKS = DATA_WIDTH / WMASK_WIDTH;
   localparam int DEPTH      = 1 << ADDR_WIDTH;

   typedef enum logic {
      ST_INIT,
      ST_READY
   } state_e;

   state_e                  state_q;
   logic [ADDR_WIDTH-1:0]   initCnt_q;
   logic                    initDone_q;

   logic [DATA_WIDTH-1:0]   mem_q [DEPTH];

   logic                    accept;
   logic                    sweepWr;
   logic                    wr0;
   logic                    rd0;
   logic                    rd1;
   logic [DATA_WIDTH-1:0]   rd1Word_d;

   logic                    rdVld0_q;
   logic                    rdVld1_q;
   logic [DATA_WIDTH-1:0]   rdData0_q;
   logic [DATA_WIDTH-1:0]   rdData1_q;
   logic                    outVld0_q;
   logic                    outVld1_q;
   logic [DATA_WIDTH-1:0]   outData0_q;
   logic [DATA_WIDTH-1:0]   outData1_q;

   // Requests only count once the array is known-clean; everything earlier is dropped.
   assign accept  = initDone_q;
   assign sweepWr = (state_q == ST_INIT);
   assign wr0     = accept & ~csb0 & ~web0;
   assign rd0     = accept & ~csb0 &  web0;
   assign rd1     = accept & ~csb1;

   // Sweep sequencer: walk every address once, then settle in READY and flag init_done.
   always_ff @(posedge clk or negedge rstb) begin
      if (!rstb) begin
         if (CLEAR_ON_RESET != 0) begin
            state_q <= ST_INIT;
         end else begin
            state_q <= ST_READY;
         end
         initCnt_q  <= '0;
         initDone_q <= 1'b0;
      end else begin
         case (state_q)
            ST_INIT: begin
               if (initCnt_q == ADDR_WIDTH'(DEPTH - 1)) begin
                  state_q    <= ST_READY;
                  initDone_q <= 1'b1;
               end else begin
                  initCnt_q <= initCnt_q + 1'b1;
               end
            end
            ST_READY: begin
               initDone_q <= 1'b1;
            end
            default: begin
               state_q <= ST_READY;
            end
         endcase
      end
   end

   // Storage array: zeroed word-by-word during the sweep, lane-masked writes afterwards.
   always_ff @(posedge clk) begin
      if (sweepWr) begin
         mem_q[initCnt_q] <= '0;
      end else if (wr0) begin
         for (int i = 0; i < NUM_WMASKS; i++) begin
            if (wmask0[i]) begin
               mem_q[addr0][i*WMASK_WIDTH +: WMASK_WIDTH] <= din0[i*WMASK_WIDTH +: WMASK_WIDTH];
            end
         end
      end
   end

   // Port 1 read word: in write-through mode a same-edge write to the same address
   // overrides the masked lanes so the reader sees the data being written.
   always_comb begin
      rd1Word_d = mem_q[addr1];
      if ((COLLISION_MODE != 0) && wr0 && (addr0 == addr1)) begin
         for (int i = 0; i < NUM_WMASKS; i++) begin
            if (wmask0[i]) begin
               rd1Word_d[i*WMASK_WIDTH +: WMASK_WIDTH] = din0[i*WMASK_WIDTH +: WMASK_WIDTH];
            end
         end
      end
   end

   // Read pipeline: capture at the request edge, present one edge later; data holds between reads.
   always_ff @(posedge clk or negedge rstb) begin
      if (!rstb) begin
         rdVld0_q   <= 1'b0;
         rdVld1_q   <= 1'b0;
         rdData0_q  <= '0;
         rdData1_q  <= '0;
         outVld0_q  <= 1'b0;
         outVld1_q  <= 1'b0;
         outData0_q <= '0;
         outData1_q <= '0;
      end else begin
         rdVld0_q  <= rd0;
         rdVld1_q  <= rd1;
         if (rd0) begin
            rdData0_q <= mem_q[addr0];
         end
         if (rd1) begin
            rdData1_q <= rd1Word_d;
         end
         outVld0_q <= rdVld0_q;
         outVld1_q <= rdVld1_q;
         if (rdVld0_q) begin
            outData0_q <= rdData0_q;
         end
         if (rdVld1_q) begin
            outData1_q <= rdData1_q;
         end
      end
   end

   generate
      if (READ_LATENCY == 2) begin : gLat2
         logic                  extVld0_q;
         logic                  extVld1_q;
         logic [DATA_WIDTH-1:0] extData0_q;
         logic [DATA_WIDTH-1:0] extData1_q;

         // Extra output register stage for the two-clock latency option.
         always_ff @(posedge clk or negedge rstb) begin
            if (!rstb) begin
               extVld0_q  <= 1'b0;
               extVld1_q  <= 1'b0;
               extData0_q <= '0;
               extData1_q <= '0;
            end else begin
               extVld0_q <= outVld0_q;
               extVld1_q <= outVld1_q;
               if (outVld0_q) begin
                  extData0_q <= outData0_q;
               end
               if (outVld1_q) begin
                  extData1_q <= outData1_q;
               end
            end
         end

         assign dout0     = extData0_q;
         assign dout0_vld = extVld0_q;
         assign dout1     = extData1_q;
         assign dout1_vld = extVld1_q;
      end else begin : gLat1
         assign dout0     = outData0_q;
         assign dout0_vld = outVld0_q;
         assign dout1     = outData1_q;
         assign dout1_vld = outVld1_q;
      end
   endgenerate

   assign init_done = initDone_q;

endmodule

// File: tb/tb_sram_1rw1r_param.sv
// tb_sram_1rw1r_param: directed bench for sram_1rw1r_param.
// Three instances share all inputs: default (latency 1, write-through),
// read-first collision variant, and latency-2 variant.
module tb_sram_1rw1r_param;

   logic        clk;
   logic        rstb;
   logic        csb0;
   logic        web0;
   logic [3:0]  wmask0;
   logic [7:0]  addr0;
   logic [31:0] din0;
   logic        csb1;
   logic [7:0]  addr1;

   logic [31:0] dout0;
   logic [31:0] dout1;
   logic        dout0Vld;
   logic        dout1Vld;
   logic        initDone;

   logic [31:0] dout0M0;
   logic [31:0] dout1M0;
   logic        dout0VldM0;
   logic        dout1VldM0;
   logic        initDoneM0;

   logic [31:0] dout0L2;
   logic [31:0] dout1L2;
   logic        dout0VldL2;
   logic        dout1VldL2;
   logic        initDoneL2;

   int checks;
   int errors;
   int vldDuringInit;
   int cyc;

   sram_1rw1r_param #(
      .READ_LATENCY(1),
      .COLLISION_MODE(1)
   ) dut (
      .clk(clk), .rstb(rstb),
      .csb0(csb0), .web0(web0), .wmask0(wmask0), .addr0(addr0), .din0(din0),
      .dout0(dout0), .dout0_vld(dout0Vld),
      .csb1(csb1), .addr1(addr1),
      .dout1(dout1), .dout1_vld(dout1Vld),
      .init_done(initDone)
   );

   sram_1rw1r_param #(
      .READ_LATENCY(1),
      .COLLISION_MODE(0)
   ) dutM0 (
      .clk(clk), .rstb(rstb),
      .csb0(csb0), .web0(web0), .wmask0(wmask0), .addr0(addr0), .din0(din0),
      .dout0(dout0M0), .dout0_vld(dout0VldM0),
      .csb1(csb1), .addr1(addr1),
      .dout1(dout1M0), .dout1_vld(dout1VldM0),
      .init_done(initDoneM0)
   );

   sram_1rw1r_param #(
      .READ_LATENCY(2),
      .COLLISION_MODE(1)
   ) dutL2 (
      .clk(clk), .rstb(rstb),
      .csb0(csb0), .web0(web0), .wmask0(wmask0), .addr0(addr0), .din0(din0),
      .dout0(dout0L2), .dout0_vld(dout0VldL2),
      .csb1(csb1), .addr1(addr1),
      .dout1(dout1L2), .dout1_vld(dout1VldL2),
      .init_done(initDoneL2)
   );

   // Free-running 10-unit clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   // One clock: through the rising edge, back to the falling edge for sampling/driving.
   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   // Counts edges until init_done, bounded; notes any vld pulse seen meanwhile.
   task automatic waitInit(output int edges);
      edges = 0;
      while (initDone !== 1'b1 && edges < 400) begin
         tick();
         edges++;
         if (dout0Vld || dout1Vld || dout0VldM0 || dout1VldM0 || dout0VldL2 || dout1VldL2) begin
            vldDuringInit++;
         end
      end
   endtask

   task automatic applyStimulus(input logic [7:0] a, input logic [31:0] d, input logic [3:0] m);
      csb0   = 1'b0;
      web0   = 1'b0;
      addr0  = a;
      din0   = d;
      wmask0 = m;
      tick();
      csb0   = 1'b1;
      web0   = 1'b1;
   endtask

   task automatic readBoth(input logic [7:0] a0, input logic [7:0] a1);
      csb0  = 1'b0;
      web0  = 1'b1;
      addr0 = a0;
      csb1  = 1'b0;
      addr1 = a1;
      tick();
      csb0  = 1'b1;
      csb1  = 1'b1;
      tick();
   endtask

   initial begin
      checks        = 0;
      errors        = 0;
      vldDuringInit = 0;
      rstb   = 1'b0;
      csb0   = 1'b1;
      web0   = 1'b1;
      wmask0 = 4'h0;
      addr0  = 8'h00;
      din0   = 32'h0;
      csb1   = 1'b1;
      addr1  = 8'h00;

      // Reset state.
      @(negedge clk);
      @(negedge clk);
      checkOutput("reset dout0", dout0, 32'h0);
      checkOutput("reset dout1", dout1, 32'h0);
      checkOutput("reset vld0", {31'h0, dout0Vld}, 32'h0);
      checkOutput("reset vld1", {31'h0, dout1Vld}, 32'h0);
      checkOutput("reset init_done", {31'h0, initDone}, 32'h0);

      // Release reset with a write and a read held during the sweep: both must be dropped.
      rstb   = 1'b1;
      csb0   = 1'b0;
      web0   = 1'b0;
      addr0  = 8'h01;
      din0   = 32'hFFFF_FFFF;
      wmask0 = 4'hF;
      csb1   = 1'b0;
      addr1  = 8'h01;
      waitInit(cyc);
      csb0 = 1'b1;
      web0 = 1'b1;
      csb1 = 1'b1;
      checkOutput("sweep length", 32'(cyc), 32'd256);
      checkOutput("no vld during init", 32'(vldDuringInit), 32'd0);
      checkOutput("init_done M0", {31'h0, initDoneM0}, 32'h1);
      checkOutput("init_done L2", {31'h0, initDoneL2}, 32'h1);

      // Dropped write left address 1 clear; extremes read zero.
      readBoth(8'h01, 8'h00);
      checkOutput("rd 0x01 after dropped wr", dout0, 32'h0);
      checkOutput("rd 0x01 vld0", {31'h0, dout0Vld}, 32'h1);
      checkOutput("rd 0x00 p1", dout1, 32'h0);
      checkOutput("rd 0x00 vld1", {31'h0, dout1Vld}, 32'h1);
      readBoth(8'hFF, 8'hFF);
      checkOutput("rd 0xFF p0", dout0, 32'h0);
      checkOutput("rd 0xFF p1", dout1, 32'h0);

      // Full write, readback, then masked write that must not disturb dout0.
      applyStimulus(8'h10, 32'hDEAD_BEEF, 4'b1111);
      checkOutput("write no vld0", {31'h0, dout0Vld}, 32'h0);
      readBoth(8'h10, 8'h10);
      checkOutput("rd 0x10 full p0", dout0, 32'hDEAD_BEEF);
      applyStimulus(8'h10, 32'h1122_3344, 4'b0101);
      checkOutput("dout0 holds over write", dout0, 32'hDEAD_BEEF);
      checkOutput("vld0 low over write", {31'h0, dout0Vld}, 32'h0);
      csb1  = 1'b0;
      addr1 = 8'h10;
      tick();
      csb1  = 1'b1;
      checkOutput("p1 vld not early", {31'h0, dout1Vld}, 32'h0);
      tick();
      checkOutput("masked merge p1", dout1, 32'hDE22_BE44);
      checkOutput("masked merge vld1", {31'h0, dout1Vld}, 32'h1);
      tick();
      checkOutput("vld1 single pulse", {31'h0, dout1Vld}, 32'h0);
      checkOutput("dout1 holds", dout1, 32'hDE22_BE44);

      // Same-address collision between port0 write and port1 read.
      applyStimulus(8'h20, 32'hAAAA_AAAA, 4'b1111);
      csb0   = 1'b0;
      web0   = 1'b0;
      addr0  = 8'h20;
      din0   = 32'h5555_5555;
      wmask0 = 4'b0011;
      csb1   = 1'b0;
      addr1  = 8'h20;
      tick();
      csb0 = 1'b1;
      web0 = 1'b1;
      csb1 = 1'b1;
      tick();
      checkOutput("collision write-through", dout1, 32'hAAAA_5555);
      checkOutput("collision read-first", dout1M0, 32'hAAAA_AAAA);
      readBoth(8'h20, 8'h20);
      checkOutput("same addr p0", dout0, 32'hAAAA_5555);
      checkOutput("same addr p1", dout1, 32'hAAAA_5555);
      checkOutput("post-collision M0 p1", dout1M0, 32'hAAAA_5555);

      // Back-to-back port0 reads of 0..3 on both latency variants.
      for (int k = 0; k < 4; k++) begin
         applyStimulus(8'(k), 32'hA0A0_0000 + 32'(k), 4'hF);
      end
      for (int k = 0; k < 7; k++) begin
         if (k < 4) begin
            csb0  = 1'b0;
            web0  = 1'b1;
            addr0 = 8'(k);
         end else begin
            csb0 = 1'b1;
         end
         tick();
         checkOutput($sformatf("b2b L1 vld k=%0d", k), {31'h0, dout0Vld},
                     (k >= 1 && k <= 4) ? 32'h1 : 32'h0);
         checkOutput($sformatf("b2b L2 vld k=%0d", k), {31'h0, dout0VldL2},
                     (k >= 2 && k <= 5) ? 32'h1 : 32'h0);
         if (k >= 1 && k <= 4) begin
            checkOutput($sformatf("b2b L1 data k=%0d", k), dout0, 32'hA0A0_0000 + 32'(k - 1));
         end
         if (k >= 2 && k <= 5) begin
            checkOutput($sformatf("b2b L2 data k=%0d", k), dout0L2, 32'hA0A0_0000 + 32'(k - 2));
         end
      end

      // Asynchronous reset clears outputs without a clock edge.
      #1 rstb = 1'b0;
      #1;
      checkOutput("async rst dout0", dout0, 32'h0);
      checkOutput("async rst dout0 L2", dout0L2, 32'h0);
      checkOutput("async rst init_done", {31'h0, initDone}, 32'h0);
      @(negedge clk);
      rstb = 1'b1;

      // Abort the sweep at address 100, then confirm a full restart.
      for (int k = 0; k < 100; k++) begin
         tick();
      end
      checkOutput("mid-sweep init_done", {31'h0, initDone}, 32'h0);
      #1 rstb = 1'b0;
      #1;
      checkOutput("mid-sweep rst dout1", dout1, 32'h0);
      @(negedge clk);
      rstb = 1'b1;
      waitInit(cyc);
      checkOutput("restart sweep length", 32'(cyc), 32'd256);

      // Sweep rewrote previously written words to zero.
      readBoth(8'h10, 8'h20);
      checkOutput("cleared 0x10", dout0, 32'h0);
      checkOutput("cleared 0x20", dout1, 32'h0);
      checkOutput("cleared vld0", {31'h0, dout0Vld}, 32'h1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
